// File: rtl/wb_pipe_reg_pkg.sv
// Shared constants for the MEM->WB pipeline register: reset/enable encodings and payload sizing.
package wb_pipe_reg_pkg;

    localparam logic        RstEnable    = 1'b1;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam int unsigned NOPRegAddr   = 0;
    localparam int unsigned ZeroWord     = 0;
    localparam int unsigned WbLanesMax   = 4;

    // Packed layout is {wd, wdata, wreg, hi, lo, whilo}.
    function automatic int unsigned payload_w(input int unsigned lanes,
                                              input int unsigned data_w,
                                              input int unsigned addr_w);
        return lanes * (addr_w + data_w + 1) + 2 * data_w + 1;
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One payload register plus valid bit; clear empties the slot and returns the payload to RST_VAL.
module pipe_skid_slot
    import wb_pipe_reg_pkg::*;
#(
    parameter int unsigned    W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    logic [W-1:0] payload_q;
    logic         valid_q;

    always_ff @(posedge clk) begin
        if (rst == RstEnable || clear) begin
            valid_q   <= 1'b0;
            payload_q <= RST_VAL;
        end else if (load) begin
            valid_q   <= 1'b1;
            payload_q <= d;
        end
    end

    assign q     = payload_q;
    assign valid = valid_q;

endmodule

// File: rtl/wb_pipe_reg.sv
// MEM->WB pipeline register with valid/ready handshake, a main slot and a one-entry skid slot.
// Bubbles present reset values on every payload output so write-back never writes on them.
module wb_pipe_reg
    import wb_pipe_reg_pkg::*;
#(
    parameter int unsigned LANES   = 1,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter bit          HILO_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,

    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*ADDR_W-1:0] in_wd,
    input  logic [LANES*DATA_W-1:0] in_wdata,
    input  logic [LANES-1:0]        in_wreg,
    input  logic [DATA_W-1:0]       in_hi,
    input  logic [DATA_W-1:0]       in_lo,
    input  logic                    in_whilo,

    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*ADDR_W-1:0] out_wd,
    output logic [LANES*DATA_W-1:0] out_wdata,
    output logic [LANES-1:0]        out_wreg,
    output logic [DATA_W-1:0]       out_hi,
    output logic [DATA_W-1:0]       out_lo,
    output logic                    out_whilo
);

    localparam int unsigned PW = payload_w(LANES, DATA_W, ADDR_W);

    localparam logic [ADDR_W-1:0] NopAddr  = ADDR_W'(NOPRegAddr);
    localparam logic [DATA_W-1:0] ZeroData = DATA_W'(ZeroWord);

    localparam logic [PW-1:0] PayloadRst = {
        {LANES{NopAddr}}, {LANES{ZeroData}}, {LANES{WriteDisable}},
        ZeroData, ZeroData, WriteDisable
    };

    if (LANES < 1 || LANES > WbLanesMax) begin : g_lanes_check
        $error("wb_pipe_reg: LANES out of range");
    end

    logic [DATA_W-1:0] hi_in, lo_in;
    logic              whilo_in;
    logic [PW-1:0]     in_payload;
    logic [PW-1:0]     main_q, skid_q, main_d;
    logic              main_valid, skid_valid;
    logic              main_load, main_clear, skid_load, skid_clear;
    logic              in_fire, out_fire, main_adv;

    logic [DATA_W-1:0] hi_q, lo_q;
    logic              whilo_q;

    // With HILO_EN=0 the hi/lo fields are packed as constants and fold away.
    if (HILO_EN) begin : g_hilo_in
        assign hi_in    = in_hi;
        assign lo_in    = in_lo;
        assign whilo_in = in_whilo;
    end else begin : g_hilo_in_off
        assign hi_in    = ZeroData;
        assign lo_in    = ZeroData;
        assign whilo_in = WriteDisable;
    end

    assign in_payload = {in_wd, in_wdata, in_wreg, hi_in, lo_in, whilo_in};

    assign in_ready = (rst != RstEnable) & ~flush & ~skid_valid;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_valid & out_ready;
    assign main_adv = ~main_valid | out_fire;

    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        main_d     = skid_valid ? skid_q : in_payload;

        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (main_adv) begin
            if (skid_valid) begin
                main_load  = 1'b1;
                skid_clear = 1'b1;
            end else if (in_fire) begin
                main_load  = 1'b1;
            end else begin
                main_clear = 1'b1;
            end
        end else if (in_fire) begin
            // Main is held under stall; the accepted beat parks behind it.
            skid_load = 1'b1;
        end
    end

    pipe_skid_slot #(
        .W       (PW),
        .RST_VAL (PayloadRst)
    ) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .q     (main_q),
        .valid (main_valid)
    );

    pipe_skid_slot #(
        .W       (PW),
        .RST_VAL (PayloadRst)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_payload),
        .q     (skid_q),
        .valid (skid_valid)
    );

    // An empty main slot always holds PayloadRst, so bubbles need no output gating.
    assign out_valid = main_valid;
    assign {out_wd, out_wdata, out_wreg, hi_q, lo_q, whilo_q} = main_q;

    if (HILO_EN) begin : g_hilo_out
        assign out_hi    = hi_q;
        assign out_lo    = lo_q;
        assign out_whilo = whilo_q;
    end else begin : g_hilo_out_off
        assign out_hi    = ZeroData;
        assign out_lo    = ZeroData;
        assign out_whilo = WriteDisable;
    end

    skid_implies_main: assert property (@(posedge clk) disable iff (rst) skid_valid |-> main_valid);

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Directed bench for wb_pipe_reg (LANES=2): table-driven streaming/stall vectors plus
// hand-written reset, flush, multi-lane and reset-under-stall sequences.
module tb_wb_pipe_reg;

    localparam int unsigned LANES  = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    logic                    clk = 1'b0;
    logic                    rst, flush;
    logic                    in_valid, in_ready;
    logic [LANES*ADDR_W-1:0] in_wd;
    logic [LANES*DATA_W-1:0] in_wdata;
    logic [LANES-1:0]        in_wreg;
    logic [DATA_W-1:0]       in_hi, in_lo;
    logic                    in_whilo;
    logic                    out_valid, out_ready;
    logic [LANES*ADDR_W-1:0] out_wd;
    logic [LANES*DATA_W-1:0] out_wdata;
    logic [LANES-1:0]        out_wreg;
    logic [DATA_W-1:0]       out_hi, out_lo;
    logic                    out_whilo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_pipe_reg #(
        .LANES   (LANES),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .HILO_EN (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_wd     (in_wd),
        .in_wdata  (in_wdata),
        .in_wreg   (in_wreg),
        .in_hi     (in_hi),
        .in_lo     (in_lo),
        .in_whilo  (in_whilo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_wd    (out_wd),
        .out_wdata (out_wdata),
        .out_wreg  (out_wreg),
        .out_hi    (out_hi),
        .out_lo    (out_lo),
        .out_whilo (out_whilo)
    );

    typedef struct {
        logic        rst;
        logic        flush;
        logic        iv;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic        ordy;
        logic        exp_ir;
        logic        exp_ov;
        logic [4:0]  exp_wd;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic iv, input logic [4:0] wd, input logic [31:0] wdata,
                                input logic ordy, input logic exp_ir, input logic exp_ov,
                                input logic [4:0] exp_wd, input logic [31:0] exp_wdata);
        vec_t v;
        v.rst = 1'b0; v.flush = 1'b0; v.iv = iv; v.wd = wd; v.wdata = wdata; v.ordy = ordy;
        v.exp_ir = exp_ir; v.exp_ov = exp_ov; v.exp_wd = exp_wd; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic iv, input logic [4:0] wd,
                         input logic [31:0] wdata, input logic ordy);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_wd     = {5'd0, wd};
        in_wdata  = {32'd0, wdata};
        in_wreg   = {1'b0, iv};
        in_hi     = '0;
        in_lo     = '0;
        in_whilo  = 1'b0;
        out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset: inputs presented during rst are dropped.
        drive(1'b1, 1'b0, 1'b1, 5'd5, 32'h55, 1'b1);
        check("rst_in_ready", in_ready, 0);
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_wd", out_wd, 0);
        check("rst_out_wreg", out_wreg, 0);
        check("rst_out_hilo", {out_hi, out_lo}, 0);
        check("post_rst_in_ready", in_ready, 1);
        tick();
        check("post_rst_bubble", out_valid, 0);

        // Streaming: each beat visible one cycle later, in order.
        for (int i = 1; i <= 8; i++) begin
            vecs.push_back(mk(1'b1, 5'(i), 32'h100 + 32'(i), 1'b1, 1'b1, 1'b1, 5'(i),
                              32'h100 + 32'(i)));
        end
        vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0));
        // Stall: A held, B parks in skid, C refused, then A and B drain back to back.
        vecs.push_back(mk(1'b1, 5'd3, 32'h203, 1'b0, 1'b1, 1'b1, 5'd3, 32'h203));
        vecs.push_back(mk(1'b1, 5'd4, 32'h204, 1'b0, 1'b1, 1'b1, 5'd3, 32'h203));
        vecs.push_back(mk(1'b1, 5'd9, 32'h209, 1'b0, 1'b0, 1'b1, 5'd3, 32'h203));
        vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd4, 32'h204));
        vecs.push_back(mk(1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].wd, vecs[i].wdata,
                  vecs[i].ordy);
            check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_ir);
            tick();
            check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_ov);
            check($sformatf("vec%0d_out_wd", i), out_wd, {5'd0, vecs[i].exp_wd});
            check($sformatf("vec%0d_out_wdata", i), out_wdata, {32'd0, vecs[i].exp_wdata});
            check($sformatf("vec%0d_out_wreg", i), out_wreg, {1'b0, vecs[i].exp_ov});
        end

        // Flush with both slots full: A and B must never appear.
        drive(1'b0, 1'b0, 1'b1, 5'd3, 32'h203, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 5'd4, 32'h204, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 5'd9, 32'h209, 1'b1);
        check("flush_full_out_wd", out_wd, 10'd3);
        check("flush_in_ready", in_ready, 0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        check("flush_out_valid", out_valid, 0);
        check("flush_out_wreg", out_wreg, 0);
        check("flush_out_wd", out_wd, 0);
        check("flush_in_ready_after", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("flush_drain%0d_valid", i), out_valid, 0);
            check($sformatf("flush_drain%0d_wd", i), out_wd, 0);
        end

        // Two lanes plus HI/LO pass through field for field.
        drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 1'b1);
        in_wd    = {5'd7, 5'd2};
        in_wdata = {32'h2222_2222, 32'h1111_1111};
        in_wreg  = 2'b10;
        in_whilo = 1'b1;
        in_hi    = 32'hDEAD;
        in_lo    = 32'hBEEF;
        tick();
        check("lanes_out_valid", out_valid, 1);
        check("lanes_out_wd", out_wd, {5'd7, 5'd2});
        check("lanes_out_wdata", out_wdata, {32'h2222_2222, 32'h1111_1111});
        check("lanes_out_wreg", out_wreg, 2'b10);
        check("lanes_out_hi", out_hi, 32'hDEAD);
        check("lanes_out_lo", out_lo, 32'hBEEF);
        check("lanes_out_whilo", out_whilo, 1);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        tick();
        check("bubble_out_valid", out_valid, 0);
        check("bubble_out_hilo", {out_hi, out_lo}, 0);
        check("bubble_out_whilo", out_whilo, 0);
        check("bubble_out_wreg", out_wreg, 0);

        // Reset in the middle of a full stall, then a fresh beat.
        drive(1'b0, 1'b0, 1'b1, 5'd3, 32'h203, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 5'd4, 32'h204, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 5'd9, 32'h209, 1'b0);
        check("midrst_full_wd", out_wd, 10'd3);
        check("midrst_in_ready", in_ready, 0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 5'd6, 32'h306, 1'b1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_wd", out_wd, 0);
        check("midrst_out_wdata", out_wdata, 0);
        check("midrst_out_wreg", out_wreg, 0);
        check("midrst_in_ready_after", in_ready, 1);
        tick();
        check("midrst_beat_valid", out_valid, 1);
        check("midrst_beat_wd", out_wd, 10'd6);
        check("midrst_beat_wdata", out_wdata, 64'h306);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        tick();
        check("midrst_no_stale", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
